// File: rtl/example_register_pkg.sv
// example_register_pkg: shared register/descriptor types for the DMA pool event scheduler
// Contents:
//   sched_state_t         - scheduler FSM state
//   dma_pool_descriptor_t - readable register image of one pool
//   pool_event_t          - per-pool event state (buffer ID, pending, sequence)
package example_register_pkg;

    localparam int EVT_ID_BITS = 16;
    localparam int SUB_BITS    = 32;
    localparam int SEQ_BITS    = 32;
    localparam int DROP_BITS   = 16;

    typedef enum logic {
        S_IDLE,
        S_COMMIT
    } sched_state_t;

    typedef struct packed {
        logic                   enabled;
        logic [SUB_BITS-1:0]    client_subscription;
        logic [EVT_ID_BITS-1:0] event_buffer;
        logic                   event_pending;
        logic [SEQ_BITS-1:0]    sequence_number;
        logic [DROP_BITS-1:0]   drop_count;
    } dma_pool_descriptor_t;

    typedef struct packed {
        logic [EVT_ID_BITS-1:0] buffer_id;
        logic                   pending;
        logic [SEQ_BITS-1:0]    sequence_number;
    } pool_event_t;

endpackage

// File: rtl/pool_rr_arbiter.sv
// pool_rr_arbiter: combinational round-robin pick among pool requests
// Ports:
//   req   - request vector, one bit per pool
//   ptr   - pool index where the search starts
//   grant - one-hot grant (all zero when nothing requests)
//   idx   - index of the granted pool (0 when nothing requests)
module pool_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] c;
    logic          hit;

    // Scan farthest-first so the candidate closest to ptr is the last writer.
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        c     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = IW'((int'(ptr) + k) % N);
            if (req[c]) begin
                idx = c;
                hit = 1'b1;
            end
        end
        grant[idx] = hit;
    end

endmodule

// File: rtl/dma_pool_event_scheduler.sv
// dma_pool_event_scheduler: round-robin scheduler turning pool buffer-ready requests into latched events
// Ports:
//   clk, areset_n        - clock, asynchronous active-low reset
//   req_valid/req_ready  - per-pool request handshake
//   req_buffer_id        - buffer ID per pool request
//   req_client           - target client index per pool request
//   pool_enabled         - descriptor enable bits
//   pool_ack             - per-pool acknowledge pulse
//   pool_subscription    - per-pool client subscription masks
//   event_buffer         - latched event buffer ID per pool
//   event_pending        - event latched, awaiting acknowledge
//   sequence_number      - delivered-event count per pool
//   drop_count           - saturating count of requests for unsubscribed clients
//   subscription_ready   - no pool has an event pending
module dma_pool_event_scheduler
    import example_register_pkg::*;
#(
    parameter int NUM_POOLS      = 4,
    parameter int BUFFER_ID_BITS = 16,
    parameter int NUM_CLIENTS    = 32,
    localparam int CLIENT_BITS   = $clog2(NUM_CLIENTS)
) (
    input  logic                                clk,
    input  logic                                areset_n,
    input  logic [NUM_POOLS-1:0]                req_valid,
    output logic [NUM_POOLS-1:0]                req_ready,
    input  logic [NUM_POOLS*BUFFER_ID_BITS-1:0] req_buffer_id,
    input  logic [NUM_POOLS*CLIENT_BITS-1:0]    req_client,
    input  logic [NUM_POOLS-1:0]                pool_enabled,
    input  logic [NUM_POOLS-1:0]                pool_ack,
    input  logic [NUM_POOLS*NUM_CLIENTS-1:0]    pool_subscription,
    output logic [NUM_POOLS*BUFFER_ID_BITS-1:0] event_buffer,
    output logic [NUM_POOLS-1:0]                event_pending,
    output logic [NUM_POOLS*SEQ_BITS-1:0]       sequence_number,
    output logic [DROP_BITS-1:0]                drop_count,
    output logic                                subscription_ready
);

    localparam int IW = (NUM_POOLS > 1) ? $clog2(NUM_POOLS) : 1;

    sched_state_t                  state, state_nx;
    logic [IW-1:0]                 gnt_idx, rr_ptr, arb_idx;
    logic [NUM_POOLS-1:0]          eligible, arb_grant;
    logic                          arb_any, fire, sub_hit;
    pool_event_t [NUM_POOLS-1:0]   ev;
    logic [BUFFER_ID_BITS-1:0]     bid [NUM_POOLS];
    logic [CLIENT_BITS-1:0]        cli [NUM_POOLS];
    logic [NUM_CLIENTS-1:0]        msk [NUM_POOLS];

    genvar g;
    generate
        for (g = 0; g < NUM_POOLS; g++) begin : g_pool
            assign bid[g] = req_buffer_id[g*BUFFER_ID_BITS +: BUFFER_ID_BITS];
            assign cli[g] = req_client[g*CLIENT_BITS +: CLIENT_BITS];
            assign msk[g] = pool_subscription[g*NUM_CLIENTS +: NUM_CLIENTS];
            assign event_buffer[g*BUFFER_ID_BITS +: BUFFER_ID_BITS] = BUFFER_ID_BITS'(ev[g].buffer_id);
            assign event_pending[g] = ev[g].pending;
            assign sequence_number[g*SEQ_BITS +: SEQ_BITS] = ev[g].sequence_number;
        end
    endgenerate

    assign eligible           = req_valid & pool_enabled & ~event_pending;
    assign arb_any            = |arb_grant;
    assign subscription_ready = ~|event_pending;
    // A pool disabled between grant and commit is skipped without a transfer.
    assign fire               = (state == S_COMMIT) && pool_enabled[gnt_idx];
    assign sub_hit            = msk[gnt_idx][cli[gnt_idx]];

    pool_rr_arbiter #(
        .N  (NUM_POOLS),
        .IW (IW)
    ) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        if (state == S_IDLE) begin
            state_nx = arb_any ? S_COMMIT : S_IDLE;
        end else begin
            state_nx           = S_IDLE;
            req_ready[gnt_idx] = pool_enabled[gnt_idx];
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= S_IDLE;
            gnt_idx    <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
            ev         <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && arb_any) gnt_idx <= arb_idx;
            if (fire) begin
                rr_ptr <= (gnt_idx == IW'(NUM_POOLS - 1)) ? '0 : gnt_idx + 1'b1;
                if (!sub_hit && drop_count != '1) drop_count <= drop_count + 1'b1;
            end
            // Granted pools always have pending clear, so a commit never races its own ack.
            for (int i = 0; i < NUM_POOLS; i++) begin
                if (fire && sub_hit && gnt_idx == IW'(i)) begin
                    ev[i].buffer_id       <= EVT_ID_BITS'(bid[gnt_idx]);
                    ev[i].pending         <= 1'b1;
                    ev[i].sequence_number <= ev[i].sequence_number + 1'b1;
                end else if (pool_ack[i] || !pool_enabled[i]) begin
                    ev[i].pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_pool_event_scheduler.sv
// tb_dma_pool_event_scheduler: directed self-checking bench with a grant-order scoreboard
module tb_dma_pool_event_scheduler;
    import example_register_pkg::*;

    logic         clk = 1'b0;
    logic         areset_n;
    logic [3:0]   req_valid, req_ready, pool_enabled, pool_ack, event_pending;
    logic [63:0]  req_buffer_id, event_buffer;
    logic [19:0]  req_client;
    logic [127:0] pool_subscription, sequence_number;
    logic [15:0]  drop_count;
    logic         subscription_ready;

    int          errors = 0;
    int          checks = 0;
    int          exp_q[$];
    bit          auto_ack;
    bit          re0;
    int          n;
    pool_event_t [3:0] fv;

    dma_pool_event_scheduler dut (
        .clk                (clk),
        .areset_n           (areset_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_buffer_id      (req_buffer_id),
        .req_client         (req_client),
        .pool_enabled       (pool_enabled),
        .pool_ack           (pool_ack),
        .pool_subscription  (pool_subscription),
        .event_buffer       (event_buffer),
        .event_pending      (event_pending),
        .sequence_number    (sequence_number),
        .drop_count         (drop_count),
        .subscription_ready (subscription_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: score any grant, optionally ack pending pools, advance past the edge, release transferred requests.
    task automatic step();
        logic [3:0] r;
        r = req_ready;
        if (r != 4'b0) begin
            chk("ready_onehot", 64'($onehot(r)), 1);
            if (exp_q.size() == 0) chk("grant_unexpected", r, 0);
            else chk("grant_order", r, 4'b1 << exp_q.pop_front());
        end
        pool_ack = pool_ack | (auto_ack ? event_pending : 4'b0);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~r;
        pool_ack  = 4'b0;
    endtask

    task automatic serve(int p, logic [15:0] id, logic [4:0] cl);
        int k;
        req_buffer_id[p*16 +: 16] = id;
        req_client[p*5 +: 5]      = cl;
        req_valid[p]              = 1'b1;
        exp_q.push_back(p);
        k = 0;
        while (req_valid[p] && k < 20) begin
            step();
            k++;
        end
        chk("serve_timeout", req_valid[p], 0);
    endtask

    task automatic reset_checks();
        chk("rst_ready", req_ready, 0);
        chk("rst_pending", event_pending, 0);
        chk("rst_buffer", event_buffer, 0);
        chk("rst_seq", sequence_number[63:0], 0);
        chk("rst_seq_hi", sequence_number[127:64], 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_subrdy", subscription_ready, 1);
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        areset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        areset_n = 1'b1; req_valid = '0; pool_enabled = '0; pool_ack = '0;
        req_buffer_id = '0; req_client = '0; pool_subscription = '0; auto_ack = 0;
        #1 areset_n = 1'b0;
        #1 reset_checks();
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        pool_enabled = 4'hF;

        // Single subscribed request on pool 1, latency N -> N+1 -> N+2
        req_buffer_id[16 +: 16] = 16'h0042;
        req_client[5 +: 5] = 5'd3;
        pool_subscription[32 +: 32] = 32'h8;
        req_valid[1] = 1'b1;
        exp_q.push_back(1);
        chk("lat_cycle_n", req_ready, 0);
        step();
        chk("lat_ready_n1", req_ready, 4'b0010);
        step();
        chk("t1_buf", event_buffer[16 +: 16], 16'h0042);
        chk("t1_pend", event_pending, 4'b0010);
        chk("t1_seq", sequence_number[32 +: 32], 1);
        chk("t1_subrdy", subscription_ready, 0);
        pool_ack[1] = 1'b1;
        step();
        chk("ack_clear", event_pending, 0);
        chk("ack_buf_hold", event_buffer[16 +: 16], 16'h0042);
        chk("ack_subrdy", subscription_ready, 1);

        // Round robin across all pools with immediate acks
        do_reset();
        pool_subscription = '1;
        req_buffer_id = {16'h00D3, 16'h00C2, 16'h00B1, 16'h00A0};
        req_valid = 4'hF;
        exp_q = '{0, 1, 2, 3, 0};
        auto_ack = 1;
        re0 = 0;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            step();
            if (!req_valid[0] && !re0) begin
                req_valid[0] = 1'b1;
                re0 = 1;
            end
        end
        chk("rr_all_granted", exp_q.size(), 0);
        step();
        step();
        auto_ack = 0;
        chk("rr_pending_clear", event_pending, 0);
        chk("rr_seq0", sequence_number[0 +: 32], 2);
        chk("rr_seq3", sequence_number[96 +: 32], 1);
        chk("rr_buf3", event_buffer[48 +: 16], 16'h00D3);

        // Unsubscribed client on pool 2 is dropped; drop counter saturates
        pool_subscription[64 +: 32] = 32'h0;
        serve(2, 16'h1234, 5'd5);
        chk("drop_count1", drop_count, 1);
        chk("drop_pend2", event_pending[2], 0);
        chk("drop_seq2", sequence_number[64 +: 32], 1);
        chk("drop_buf2", event_buffer[32 +: 16], 16'h00C2);
        force dut.drop_count = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.drop_count;
        serve(2, 16'h1235, 5'd5);
        chk("drop_to_max", drop_count, 16'hFFFF);
        serve(2, 16'h1236, 5'd5);
        chk("drop_sat_hold", drop_count, 16'hFFFF);

        // Pending pool 0 blocks a new request until acknowledged
        serve(0, 16'h0E00, 5'd1);
        chk("blk_pend0", event_pending, 4'b0001);
        req_buffer_id[0 +: 16] = 16'h0E01;
        req_valid[0] = 1'b1;
        exp_q.push_back(0);
        for (int c = 0; c < 4; c++) begin
            chk("pend_blocks", req_ready, 0);
            step();
        end
        pool_ack[0] = 1'b1;
        step();
        n = 1;
        while (!req_ready[0] && n < 6) begin
            step();
            n++;
        end
        chk("ack_regrant_lat", n, 2);
        step();
        chk("regrant_buf0", event_buffer[0 +: 16], 16'h0E01);
        chk("regrant_seq0", sequence_number[0 +: 32], 4);

        // Ack on pool 0 in the same cycle as a commit on pool 2
        pool_subscription[64 +: 32] = 32'hFFFF_FFFF;
        req_buffer_id[32 +: 16] = 16'h2828;
        req_client[10 +: 5] = 5'd7;
        req_valid[2] = 1'b1;
        exp_q.push_back(2);
        n = 0;
        while (!req_ready[2] && n < 5) begin
            step();
            n++;
        end
        chk("commit_seen", req_ready, 4'b0100);
        pool_ack[0] = 1'b1;
        step();
        chk("ack_and_commit", event_pending, 4'b0100);
        chk("ack_and_commit_buf", event_buffer[32 +: 16], 16'h2828);
        pool_ack[2] = 1'b1;
        step();
        chk("subrdy_again", subscription_ready, 1);

        // Pool 3 disabled mid-commit, then sequence wrap
        do_reset();
        fv = '0;
        fv[3].sequence_number = 32'hFFFF_FFFF;
        force dut.ev = fv;
        @(posedge clk);
        #1;
        release dut.ev;
        req_buffer_id[48 +: 16] = 16'h3333;
        req_client[15 +: 5] = 5'd9;
        req_valid[3] = 1'b1;
        step();
        pool_enabled[3] = 1'b0;
        #1;
        chk("disabled_no_ready", req_ready, 0);
        step();
        chk("disabled_pend3", event_pending[3], 0);
        chk("disabled_seq3", sequence_number[96 +: 32], 32'hFFFF_FFFF);
        chk("disabled_buf3", event_buffer[48 +: 16], 0);
        exp_q.push_back(3);
        pool_enabled[3] = 1'b1;
        n = 0;
        while (req_valid[3] && n < 10) begin
            step();
            n++;
        end
        chk("wrap_seq3", sequence_number[96 +: 32], 0);
        chk("wrap_pend3", event_pending[3], 1);
        chk("wrap_buf3", event_buffer[48 +: 16], 16'h3333);
        pool_enabled[3] = 1'b0;
        step();
        chk("disable_clears_pend", event_pending[3], 0);
        chk("disable_keeps_seq", sequence_number[96 +: 32], 0);
        pool_enabled[3] = 1'b1;

        // Reset asserted while pool 1 is in COMMIT; requester re-presents afterwards
        req_buffer_id[16 +: 16] = 16'h4141;
        req_client[5 +: 5] = 5'd3;
        req_valid[1] = 1'b1;
        exp_q.push_back(1);
        n = 0;
        while (!req_ready[1] && n < 5) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("commit_before_reset", req_ready, 4'b0010);
        areset_n = 1'b0;
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        n = 0;
        while (req_valid[1] && n < 10) begin
            step();
            n++;
        end
        chk("represent_done", req_valid[1], 0);
        chk("represent_pend", event_pending, 4'b0010);
        chk("represent_seq1", sequence_number[32 +: 32], 1);
        chk("represent_buf1", event_buffer[16 +: 16], 16'h4141);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_pool_event_scheduler.md
DMA_POOL_EVENT_SCHEDULER -- requirements
Module: dma_pool_event_scheduler

Interface
REQ-001 Parameter NUM_POOLS, default 4: number of DMA pools scheduled.
REQ-002 Parameter BUFFER_ID_BITS, default 16: width of a buffer ID.
REQ-003 Parameter NUM_CLIENTS, default 32: width of a subscription mask; CLIENT_BITS = $clog2(NUM_CLIENTS).
REQ-004 clk  in  1  clock.
REQ-005 areset_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  NUM_POOLS  per-pool buffer-ready request.
REQ-007 req_ready  out  NUM_POOLS  per-pool request accept.
REQ-008 req_buffer_id  in  NUM_POOLS*BUFFER_ID_BITS  buffer ID per pool request.
REQ-009 req_client  in  NUM_POOLS*CLIENT_BITS  target client index per pool request.
REQ-010 pool_enabled  in  NUM_POOLS  descriptor enabled bits.
REQ-011 pool_ack  in  NUM_POOLS  one-cycle acknowledge_event pulse per pool.
REQ-012 pool_subscription  in  NUM_POOLS*NUM_CLIENTS  client_subscription masks.
REQ-013 event_buffer  out  NUM_POOLS*BUFFER_ID_BITS  latched event buffer ID per pool.
REQ-014 event_pending  out  NUM_POOLS  event latched, awaiting acknowledge.
REQ-015 sequence_number  out  NUM_POOLS*32  delivered-event count per pool.
REQ-016 drop_count  out  16  requests dropped for unsubscribed clients, all pools.
REQ-017 subscription_ready  out  1  high when no pool has event_pending set.

Function
REQ-018 Handshake: transfer when req_valid & req_ready high on the same clk edge; requester holds valid and payload stable until ready.
REQ-019 Pool eligible when req_valid=1, pool_enabled=1, event_pending=0.
REQ-020 FSM states IDLE, COMMIT; IDLE: if any pool eligible, round-robin pick registered into grant index -> COMMIT; else stay IDLE.
REQ-021 Round-robin pointer starts at pool 0; after a commit or drop on pool k, search starts at k+1 mod NUM_POOLS.
REQ-022 COMMIT: if granted pool still enabled, assert req_ready for that pool only, one cycle, then -> IDLE.
REQ-023 COMMIT, client subscribed (pool_subscription bit req_client set): latch event_buffer, set event_pending, sequence_number +1 (32-bit wrap), visible cycle after COMMIT.
REQ-024 COMMIT, client not subscribed: accept and discard request, event_buffer/sequence unchanged, drop_count +1 saturating at 16'hFFFF.
REQ-025 COMMIT with granted pool disabled: no req_ready, no state change, -> IDLE.
REQ-026 Latency: eligible request in cycle N -> req_ready in N+1 -> event_pending in N+2; max one grant per 2 cycles.
REQ-027 pool_ack with event_pending=1 clears it next cycle; event_buffer holds value; ack with pending=0 ignored.
REQ-028 Ack on pool A same cycle as COMMIT on pool B: both take effect.
REQ-029 pool_enabled falling clears that pool's event_pending next cycle; sequence_number retained.
REQ-030 At most one req_ready bit high in any cycle.

Reset
REQ-031 areset_n low asynchronously forces FSM=IDLE, RR pointer=0, req_ready=0, event_pending=0, event_buffer=0, sequence_number=0, drop_count=0, subscription_ready=1.
REQ-032 Reset mid-COMMIT: no transfer completes; requester re-presents after reset release.

Structure
REQ-033 FSM state enum and per-pool event typedef (buffer ID, pending, sequence) SHALL live in example_register_pkg alongside dma_pool_descriptor_t.
REQ-034 Round-robin selection SHALL be sub-module pool_rr_arbiter (request vector, pointer in, one-hot grant and index out).
REQ-035 Output widths SHALL match dma_pool_descriptor_t fields so outputs wire straight into readable_registers.

Verification
REQ-036 Pool 1 valid, ID 16'h0042, client 3, mask 32'h8: req_ready[1] 1 cycle later, event_buffer[1]=16'h0042, pending[1]=1, sequence_number[1]=1.
REQ-037 All 4 pools valid, all subscribed, acks immediate: grants in order 0,1,2,3,0; no req_ready overlap.
REQ-038 Pool 2 client 5, mask 32'h0: request accepted, drop_count=1, pending[2]=0; 65536 drops hold at 16'hFFFF.
REQ-039 Pending[0]=1, second request on pool 0: no req_ready until pool_ack[0]; grant within 2 cycles after ack.
REQ-040 pool_enabled[3] dropped during COMMIT: no req_ready[3], pending[3]=0; sequence 32'hFFFFFFFF +1 -> 0.
REQ-041 areset_n low during COMMIT: all outputs at reset values, subscription_ready=1.
